// File: rtl/aznable_pkg.sv
// Shared constants and types for the Aznable HPS download scheduler.
package aznable_pkg;

   localparam logic [7:0] DN_IDX_BIOS    = 8'd0;
   localparam logic [7:0] DN_IDX_BIOS_HI = 8'd1;
   localparam logic [7:0] DN_IDX_SPR     = 8'd3;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_DL   = 2'd1,
      ST_HOLD = 2'd2
   } rst_state_t;

   function automatic logic is_prog_index(input logic [7:0] idx);
      return (idx == DN_IDX_BIOS) || (idx == DN_IDX_BIOS_HI);
   endfunction

endpackage

// File: rtl/dn_skid.sv
// One-entry {addr, data} holding register for sprite writes that lose arbitration.
module dn_skid
   import aznable_pkg::*;
#(
   parameter int AW = 12
) (
   input  logic          clk_sys,
   input  logic          reset_n,
   input  logic          push,
   input  logic          pop,
   input  logic [AW-1:0] push_addr,
   input  logic [7:0]    push_data,
   output logic          full,
   output logic [AW-1:0] addr,
   output logic [7:0]    data
);

   logic          full_reg;
   logic [AW-1:0] addr_reg;
   logic [7:0]    data_reg;

   // A push in the same cycle as a pop refills the entry, so push wins.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         full_reg <= 1'b0;
         addr_reg <= '0;
         data_reg <= '0;
      end else if (push) begin
         full_reg <= 1'b1;
         addr_reg <= push_addr;
         data_reg <= push_data;
      end else if (pop) begin
         full_reg <= 1'b0;
      end
   end

   assign full = full_reg;
   assign addr = addr_reg;
   assign data = data_reg;

endmodule

// File: rtl/dn_mem_sched.sv
// Routes ioctl downloads to program/sprite RAM and holds the CPU in reset around them.
module dn_mem_sched
   import aznable_pkg::*;
#(
   parameter int SPR_AW     = 12,
   parameter int RESET_HOLD = 16,
   parameter int STARVE_MAX = 64
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              host_reset,
   input  logic              dn_download,
   input  logic              dn_wr,
   input  logic [16:0]       dn_addr,
   input  logic [7:0]        dn_data,
   input  logic [7:0]        dn_index,
   output logic              dn_wait,
   output logic              dn_overflow,
   output logic              cpu_reset,
   output logic              prg_we,
   output logic [15:0]       prg_addr,
   output logic [7:0]        prg_data,
   input  logic              spr_req,
   input  logic [SPR_AW-1:0] spr_addr,
   output logic              spr_ack,
   output logic [SPR_AW-1:0] spr_mem_addr,
   output logic              spr_mem_we,
   output logic [7:0]        spr_mem_din
);

   localparam int HW = $clog2(RESET_HOLD + 1);
   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [HW-1:0] HOLD_LOAD = HW'(RESET_HOLD);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

   rst_state_t        state_reg, state_next;
   logic [HW-1:0]     hold_reg, hold_next;
   logic              cpu_reset_reg;
   logic              prg_we_reg;
   logic [15:0]       prg_addr_reg;
   logic [7:0]        prg_data_reg;
   logic              spr_ack_reg, spr_we_reg;
   logic [SPR_AW-1:0] spr_addr_reg;
   logic [7:0]        spr_din_reg;
   logic [SW-1:0]     starve_reg;
   logic              overflow_reg, download_reg;

   logic              prog_dl, spr_wr;
   logic              buf_full, grant_buf, grant_eng, direct_wr, push, drop;
   logic [SPR_AW-1:0] buf_addr;
   logic [7:0]        buf_data;
   logic              unused_addr_bits;

   assign prog_dl = dn_download && is_prog_index(dn_index);
   assign spr_wr  = dn_download && dn_wr && (dn_index == DN_IDX_SPR);
   assign unused_addr_bits = ^dn_addr[16:15];

   always_comb begin
      state_next = state_reg;
      hold_next  = hold_reg;
      case (state_reg)
         ST_RUN: begin
            if (prog_dl) begin
               state_next = ST_DL;
            end else if (host_reset) begin
               state_next = ST_HOLD;
               hold_next  = HOLD_LOAD;
            end
         end
         ST_DL: begin
            if (!prog_dl) begin
               state_next = ST_HOLD;
               hold_next  = HOLD_LOAD;
            end
         end
         ST_HOLD: begin
            if (prog_dl) begin
               state_next = ST_DL;
            end else if (host_reset) begin
               hold_next = HOLD_LOAD;
            end else if (hold_reg == '0) begin
               state_next = ST_RUN;
            end else begin
               hold_next = hold_reg - HW'(1);
            end
         end
         default: begin
            state_next = ST_HOLD;
            hold_next  = HOLD_LOAD;
         end
      endcase
   end

   // The live sprite engine wins unless it has starved a full buffer too long.
   assign grant_buf = buf_full && (!spr_req || (starve_reg == STARVE_LIM));
   assign grant_eng = spr_req && !grant_buf;
   assign direct_wr = spr_wr && !buf_full && !spr_req;
   assign push      = spr_wr && !direct_wr && (!buf_full || grant_buf);
   assign drop      = spr_wr && buf_full && !grant_buf;

   dn_skid #(.AW(SPR_AW)) u_skid (
      .clk_sys   (clk_sys),
      .reset_n   (reset_n),
      .push      (push),
      .pop       (grant_buf),
      .push_addr (dn_addr[SPR_AW-1:0]),
      .push_data (dn_data),
      .full      (buf_full),
      .addr      (buf_addr),
      .data      (buf_data)
   );

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_reg     <= ST_HOLD;
         hold_reg      <= HOLD_LOAD;
         cpu_reset_reg <= 1'b1;
         prg_we_reg    <= 1'b0;
         prg_addr_reg  <= '0;
         prg_data_reg  <= '0;
         spr_ack_reg   <= 1'b0;
         spr_we_reg    <= 1'b0;
         spr_addr_reg  <= '0;
         spr_din_reg   <= '0;
         starve_reg    <= '0;
         overflow_reg  <= 1'b0;
         download_reg  <= 1'b0;
      end else begin
         state_reg     <= state_next;
         hold_reg      <= hold_next;
         cpu_reset_reg <= (state_next != ST_RUN);
         download_reg  <= dn_download;

         prg_we_reg <= dn_wr && prog_dl;
         if (dn_wr && prog_dl) begin
            prg_addr_reg <= {dn_index[0], dn_addr[14:0]};
            prg_data_reg <= dn_data;
         end

         spr_ack_reg <= grant_eng;
         spr_we_reg  <= grant_buf || direct_wr;
         if (grant_buf) begin
            spr_addr_reg <= buf_addr;
            spr_din_reg  <= buf_data;
         end else if (direct_wr) begin
            spr_addr_reg <= dn_addr[SPR_AW-1:0];
            spr_din_reg  <= dn_data;
         end else if (grant_eng) begin
            spr_addr_reg <= spr_addr;
         end

         if (!buf_full || grant_buf) begin
            starve_reg <= '0;
         end else if (grant_eng) begin
            starve_reg <= starve_reg + SW'(1);
         end

         if (drop) begin
            overflow_reg <= 1'b1;
         end else if (dn_download && !download_reg) begin
            overflow_reg <= 1'b0;
         end
      end
   end

   assign dn_wait      = buf_full;
   assign dn_overflow  = overflow_reg;
   assign cpu_reset    = cpu_reset_reg;
   assign prg_we       = prg_we_reg;
   assign prg_addr     = prg_addr_reg;
   assign prg_data     = prg_data_reg;
   assign spr_ack      = spr_ack_reg;
   assign spr_mem_addr = spr_addr_reg;
   assign spr_mem_we   = spr_we_reg;
   assign spr_mem_din  = spr_din_reg;

endmodule

// File: tb/tb_dn_mem_sched.sv
// Scoreboard bench for dn_mem_sched: stimulus queues expected writes, a monitor retires them.
module tb_dn_mem_sched;

   localparam int SPR_AW     = 12;
   localparam int RESET_HOLD = 16;
   localparam int STARVE_MAX = 64;

   logic              clk_sys = 1'b0;
   logic              reset_n = 1'b0;
   logic              host_reset = 1'b0;
   logic              dn_download = 1'b0;
   logic              dn_wr = 1'b0;
   logic [16:0]       dn_addr = '0;
   logic [7:0]        dn_data = '0;
   logic [7:0]        dn_index = '0;
   logic              spr_req = 1'b0;
   logic [SPR_AW-1:0] spr_addr = '0;
   logic              dn_wait, dn_overflow, cpu_reset, prg_we, spr_ack, spr_mem_we;
   logic [15:0]       prg_addr;
   logic [7:0]        prg_data, spr_mem_din;
   logic [SPR_AW-1:0] spr_mem_addr;

   dn_mem_sched #(.SPR_AW(SPR_AW), .RESET_HOLD(RESET_HOLD), .STARVE_MAX(STARVE_MAX)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .host_reset(host_reset),
      .dn_download(dn_download), .dn_wr(dn_wr), .dn_addr(dn_addr), .dn_data(dn_data),
      .dn_index(dn_index), .dn_wait(dn_wait), .dn_overflow(dn_overflow),
      .cpu_reset(cpu_reset), .prg_we(prg_we), .prg_addr(prg_addr), .prg_data(prg_data),
      .spr_req(spr_req), .spr_addr(spr_addr), .spr_ack(spr_ack),
      .spr_mem_addr(spr_mem_addr), .spr_mem_we(spr_mem_we), .spr_mem_din(spr_mem_din)
   );

   always #5 clk_sys = ~clk_sys;

   typedef struct {
      int a;
      int d;
      int c;   // expected observation cycle, -1 when only ordering matters
   } wr_t;

   wr_t prg_q[$];
   wr_t spr_q[$];
   int  checks = 0;
   int  failures = 0;
   int  cyc = 0;
   logic [SPR_AW-1:0] last_spr_addr = '0;
   logic              last_spr_req = 1'b0;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_exp(input bit is_prg, input int a, input int d, input int c);
      wr_t e;
      e.a = a; e.d = d; e.c = c;
      if (is_prg) prg_q.push_back(e);
      else        spr_q.push_back(e);
   endtask

   always @(posedge clk_sys) begin
      cyc           <= cyc + 1;
      last_spr_addr <= spr_addr;
      last_spr_req  <= spr_req;
   end

   // Monitor: retires expected writes as the DUT presents them.
   always @(negedge clk_sys) begin
      wr_t e;
      if (prg_we) begin
         if (prg_q.size() == 0) begin
            check("prg_unexpected_write", 1, 0);
         end else begin
            e = prg_q.pop_front();
            $display("prg write  addr=%04h data=%02h cycle=%0d", prg_addr, prg_data, cyc);
            check("prg_addr", prg_addr, e.a);
            check("prg_data", prg_data, e.d);
            check("prg_latency", cyc, e.c);
            check("prg_cpu_in_reset", cpu_reset, 1);
         end
      end
      if (spr_mem_we) begin
         if (spr_q.size() == 0) begin
            check("spr_unexpected_write", 1, 0);
         end else begin
            e = spr_q.pop_front();
            $display("spr write  addr=%03h data=%02h cycle=%0d", spr_mem_addr, spr_mem_din, cyc);
            check("spr_addr", spr_mem_addr, e.a);
            check("spr_data", spr_mem_din, e.d);
            if (e.c >= 0) check("spr_latency", cyc, e.c);
            check("spr_we_ack_exclusive", spr_ack, 0);
         end
      end
      if (spr_ack) begin
         check("ack_had_request", last_spr_req, 1);
         check("ack_addr", spr_mem_addr, last_spr_addr);
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n, acks;
      bit prev_wait, seen;
      logic [16:0] a;
      logic [7:0]  d, idx;

      // Reset values
      repeat (3) @(negedge clk_sys);
      check("rst_cpu_reset", cpu_reset, 1);
      check("rst_prg_we", prg_we, 0);
      check("rst_spr_we", spr_mem_we, 0);
      check("rst_spr_ack", spr_ack, 0);
      check("rst_dn_wait", dn_wait, 0);
      check("rst_overflow", dn_overflow, 0);
      check("rst_prg_addr", prg_addr, 0);
      check("rst_spr_addr", spr_mem_addr, 0);

      // Power-up release: RESET_HOLD decrements plus the edge that returns to RUN
      reset_n = 1'b1;
      n = 0;
      while (cpu_reset && n < 100) begin
         @(negedge clk_sys);
         n++;
      end
      check("release_edges", n, RESET_HOLD + 1);

      // Host reset pulse of 5 cycles in RUN
      n = 0;
      host_reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_sys);
         if (cpu_reset) n++;
      end
      host_reset = 1'b0;
      while (cpu_reset && n < 100) begin
         @(negedge clk_sys);
         if (cpu_reset) n++;
      end
      check("host_reset_high_cycles", n, 5 + RESET_HOLD);

      // BIOS load, first write on the first download cycle
      dn_download = 1'b1; dn_index = 8'd0; dn_wr = 1'b1;
      dn_addr = 17'h00123; dn_data = 8'hA5;
      push_exp(1, 16'h0123, 8'hA5, cyc + 1);
      @(negedge clk_sys);
      dn_wr = 1'b0;
      check("bios_cpu_reset", cpu_reset, 1);
      dn_index = 8'd1; dn_wr = 1'b1; dn_addr = 17'h00010; dn_data = 8'h3C;
      push_exp(1, 16'h8010, 8'h3C, cyc + 1);
      @(negedge clk_sys);
      dn_wr = 1'b0;
      for (int i = 0; i < 40; i++) begin
         host_reset = (i >= 15 && i < 18);
         if ($urandom_range(1, 0) == 1) begin
            idx = 8'($urandom_range(1, 0));
            a = 17'($urandom);
            d = 8'($urandom);
            dn_index = idx; dn_addr = a; dn_data = d; dn_wr = 1'b1;
            push_exp(1, {idx[0], a[14:0]}, d, cyc + 1);
         end
         @(negedge clk_sys);
         dn_wr = 1'b0;
      end
      // One edge to leave DL, then the same RESET_HOLD+1 edges as any HOLD exit
      dn_download = 1'b0;
      n = 0;
      while (cpu_reset && n < 100) begin
         @(negedge clk_sys);
         n++;
      end
      check("dl_exit_edges", n, RESET_HOLD + 2);

      // Sprite write with idle engine goes straight to the port
      dn_download = 1'b1; dn_index = 8'd3; spr_req = 1'b0;
      dn_wr = 1'b1; dn_addr = 17'h00044; dn_data = 8'h5A;
      push_exp(0, 12'h044, 8'h5A, cyc + 1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_sys);
         dn_wr = 1'b0;
         check("idle_no_wait", dn_wait, 0);
      end

      // Contention: buffered write, dropped second write, drain after spr_req falls
      spr_req = 1'b1; spr_addr = 12'($urandom);
      dn_wr = 1'b1; dn_addr = 17'h00100; dn_data = 8'hC3;
      push_exp(0, 12'h100, 8'hC3, cyc + 4);
      @(negedge clk_sys);
      dn_wr = 1'b0; spr_addr = 12'($urandom);
      check("contend_wait", dn_wait, 1);
      @(negedge clk_sys);
      dn_wr = 1'b1; dn_addr = 17'h00200; dn_data = 8'h99; spr_addr = 12'($urandom);
      @(negedge clk_sys);
      dn_wr = 1'b0;
      check("contend_overflow", dn_overflow, 1);
      check("contend_wait_held", dn_wait, 1);
      spr_req = 1'b0;
      @(negedge clk_sys);
      check("drain_wait_low", dn_wait, 0);
      dn_download = 1'b0;
      @(negedge clk_sys);
      check("overflow_sticky", dn_overflow, 1);
      dn_download = 1'b1;
      @(negedge clk_sys);
      check("overflow_cleared", dn_overflow, 0);

      // Starvation: count grants issued while the buffer was already full
      spr_req = 1'b1;
      dn_wr = 1'b1; dn_addr = 17'h00ABC; dn_data = 8'h77;
      push_exp(0, 12'hABC, 8'h77, -1);
      prev_wait = 1'b0; acks = 0; seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk_sys);
         dn_wr = 1'b0;
         if (spr_mem_we) begin
            seen = 1'b1;
            break;
         end
         if (prev_wait && spr_ack) acks++;
         prev_wait = dn_wait;
         spr_addr = 12'($urandom);
      end
      check("starve_buffer_granted", seen, 1);
      check("starve_ack_count", acks, STARVE_MAX);
      check("starve_gap_ack", spr_ack, 0);
      @(negedge clk_sys);
      check("starve_grants_resume", spr_ack, 1);
      check("starve_wait_low", dn_wait, 0);

      // Randomized traffic; host honours dn_wait so every index 3 write must land
      for (int i = 0; i < 400; i++) begin
         spr_req = ($urandom_range(9, 0) < 6);
         spr_addr = 12'($urandom);
         if (!dn_wait && $urandom_range(9, 0) < 4) begin
            a = 17'($urandom);
            d = 8'($urandom);
            dn_addr = a; dn_data = d; dn_wr = 1'b1;
            if ($urandom_range(7, 0) == 0) begin
               dn_index = 8'd2;
            end else begin
               dn_index = 8'd3;
               push_exp(0, a[SPR_AW-1:0], d, (!spr_req && !dn_wait) ? cyc + 1 : -1);
            end
         end
         @(negedge clk_sys);
         dn_wr = 1'b0;
      end
      spr_req = 1'b0;
      n = 0;
      while (spr_q.size() != 0 && n < 20) begin
         @(negedge clk_sys);
         n++;
      end
      check("random_drained", spr_q.size(), 0);
      dn_index = 8'd3;

      // Reset mid-download discards the buffer and clears overflow
      spr_req = 1'b1;
      dn_wr = 1'b1; dn_addr = 17'h00321; dn_data = 8'h11;
      @(negedge clk_sys);
      dn_wr = 1'b1; dn_addr = 17'h00322; dn_data = 8'h22;
      @(negedge clk_sys);
      dn_wr = 1'b0;
      check("midrst_wait_before", dn_wait, 1);
      check("midrst_ovf_before", dn_overflow, 1);
      #1 reset_n = 1'b0;
      #1;
      check("midrst_wait_cleared", dn_wait, 0);
      check("midrst_ovf_cleared", dn_overflow, 0);
      check("midrst_cpu_reset", cpu_reset, 1);
      @(negedge clk_sys);
      spr_req = 1'b0;
      reset_n = 1'b1;
      repeat (5) @(negedge clk_sys);
      check("midrst_no_wait", dn_wait, 0);

      check("prg_queue_empty", prg_q.size(), 0);
      check("spr_queue_empty", spr_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
